iomem_gpio: RTL

Parametrised GPIO peripheral for the PicoSoC iomem bus. It replaces the fixed 32-bit, output-only LED register in the SoC top with a memory-mapped block of NUM_PINS bidirectional pins. The block provides per-pin direction control, synchronised input readback, and optional per-pin edge-detect interrupts. It sits beside `picosoc` on the iomem port and drives one of its irq lines.

---
 rtl/iomem_gpio.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/iomem_gpio.sv
// iomem_gpio: NUM_PINS-wide memory-mapped GPIO block for the PicoSoC iomem bus.
// Define GPIO_IRQ_EN to build the edge-detect interrupt registers and the irq output.
module iomem_gpio #(
    parameter int         NUM_PINS    = 8,
    parameter logic [7:0] ADDR_HI     = 8'h03,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                iomem_valid,
    output logic                iomem_ready,
    input  logic [3:0]          iomem_wstrb,
    input  logic [31:0]         iomem_addr,
    input  logic [31:0]         iomem_wdata,
    output logic [31:0]         iomem_rdata,
    input  logic [NUM_PINS-1:0] gpio_in,
    output logic [NUM_PINS-1:0] gpio_out,
    output logic [NUM_PINS-1:0] gpio_oe,
    output logic                irq
);
    localparam logic [5:0] OFF_OUT  = 6'd0;
    localparam logic [5:0] OFF_DIR  = 6'd1;
    localparam logic [5:0] OFF_IN   = 6'd2;
    localparam logic [5:0] OFF_RISE = 6'd3;
    localparam logic [5:0] OFF_FALL = 6'd4;
    localparam logic [5:0] OFF_PEND = 6'd5;

    logic                                 r_ready;
    logic [31:0]                          r_rdata;
    logic [NUM_PINS-1:0]                  r_out;
    logic [NUM_PINS-1:0]                  r_dir;
    logic [SYNC_STAGES-1:0][NUM_PINS-1:0] r_sync;

    logic                w_sel;
    logic                w_write;
    logic [5:0]          w_offset;
    logic [31:0]         w_laneMask32;
    logic [NUM_PINS-1:0] w_laneMask;
    logic [NUM_PINS-1:0] w_wbits;
    logic [NUM_PINS-1:0] w_inSync;
    logic [NUM_PINS-1:0] w_rdPins;
    logic [31:0]         w_rdWord;

    // The !r_ready term forces a one-cycle gap so a held valid is not acknowledged twice.
    assign w_sel        = iomem_valid && (iomem_addr[31:24] == ADDR_HI) && !r_ready;
    assign w_write      = w_sel && (iomem_wstrb != 4'b0000);
    assign w_offset     = iomem_addr[7:2];
    assign w_laneMask32 = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                           {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
    assign w_laneMask   = w_laneMask32[NUM_PINS-1:0];
    assign w_wbits      = iomem_wdata[NUM_PINS-1:0];
    assign w_inSync     = r_sync[SYNC_STAGES-1];

    function automatic logic [NUM_PINS-1:0] laneMerge(input logic [NUM_PINS-1:0] oldVal,
                                                      input logic [NUM_PINS-1:0] newVal,
                                                      input logic [NUM_PINS-1:0] mask);
        return (oldVal & ~mask) | (newVal & mask);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], gpio_in};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out <= '0;
            r_dir <= '0;
        end else if (w_write) begin
            if (w_offset == OFF_OUT) r_out <= laneMerge(r_out, w_wbits, w_laneMask);
            if (w_offset == OFF_DIR) r_dir <= laneMerge(r_dir, w_wbits, w_laneMask);
        end
    end

`ifdef GPIO_IRQ_EN
    logic [NUM_PINS-1:0] r_rise;
    logic [NUM_PINS-1:0] r_fall;
    logic [NUM_PINS-1:0] r_pend;
    logic [NUM_PINS-1:0] r_prev;
    logic [NUM_PINS-1:0] w_set;
    logic [NUM_PINS-1:0] w_clr;

    assign w_set = (w_inSync & ~r_prev & r_rise) | (~w_inSync & r_prev & r_fall);
    assign w_clr = (w_write && (w_offset == OFF_PEND)) ? (w_wbits & w_laneMask) : '0;

    // Set is OR-ed in after the clear so a same-cycle edge is never lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rise <= '0;
            r_fall <= '0;
            r_pend <= '0;
            r_prev <= '0;
        end else begin
            r_prev <= w_inSync;
            r_pend <= (r_pend & ~w_clr) | w_set;
            if (w_write && (w_offset == OFF_RISE)) r_rise <= laneMerge(r_rise, w_wbits, w_laneMask);
            if (w_write && (w_offset == OFF_FALL)) r_fall <= laneMerge(r_fall, w_wbits, w_laneMask);
        end
    end

    assign irq = |r_pend;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        w_rdPins = '0;
        case (w_offset)
            OFF_OUT:  w_rdPins = r_out;
            OFF_DIR:  w_rdPins = r_dir;
            OFF_IN:   w_rdPins = w_inSync;
`ifdef GPIO_IRQ_EN
            OFF_RISE: w_rdPins = r_rise;
            OFF_FALL: w_rdPins = r_fall;
            OFF_PEND: w_rdPins = r_pend;
`endif
            default:  w_rdPins = '0;
        endcase
        w_rdWord = '0;
        w_rdWord[NUM_PINS-1:0] = w_rdPins;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ready <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ready <= w_sel;
            if (w_sel) r_rdata <= w_rdWord;
        end
    end

    assign iomem_ready = r_ready;
    assign iomem_rdata = r_rdata;
    assign gpio_out    = r_out;
    assign gpio_oe     = r_dir;
endmodule
